approx_mult_sweep_ctrl: RTL and testbench
=========================================

# approx_mult_sweep_ctrl

Sequencer that runs an exhaustive error-characterisation sweep over the configurable approximate multiplier (the partial-product reduction tree plus its final adder). It latches one per-column compressor configuration and drives it to the datapath. It then issues every operand pair `a`, `b` in `[0, 2^BITWIDTH)`, one per cycle, and compares the returned approximate product against the exact product. It accumulates error count, sum of absolute error and maximum absolute error. It sits between the host/testbench-side config loader and the multiplier datapath.

## Interface
Parameters:
- `BITWIDTH`, 8: operand width. Product width is `2*BITWIDTH`.
- `LAT`, 2: datapath latency in cycles from `op_valid_o` to product valid. Range 0..15.
- `NCOL`, `BITWIDTH`: number of low product columns with selectable first-stage compressor.

Ports (clock and reset first):
- `clk`, in, 1: single clock. All logic is rising-edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `start`, in, 1: start-sweep request, sampled in IDLE only.
- `abort`, in, 1: cancel a running sweep.
- `cfg_in`, in, `2*NCOL`: per-column compressor code, 2 bits per column, column 0 in bits [1:0].
- `cfg_o`, out, `2*NCOL`: latched configuration driven to the datapath.
- `a_o`, out, `BITWIDTH`: operand A to the datapath.
- `b_o`, out, `BITWIDTH`: operand B to the datapath.
- `op_valid_o`, out, 1: operands valid this cycle.
- `prod_approx_i`, in, `2*BITWIDTH`: approximate product, valid `LAT` cycles after issue.
- `prod_exact_i`, in, `2*BITWIDTH`: exact product, same alignment as `prod_approx_i`.
- `busy`, out, 1: sweep in progress.
- `done`, out, 1: one-cycle pulse; results are final.
- `err_cnt`, out, `2*BITWIDTH+1`: number of pairs with a nonzero error.
- `err_sum`, out, `4*BITWIDTH`: sum of `|approx - exact|`.
- `err_max`, out, `2*BITWIDTH`: largest `|approx - exact|`.

## Operation
- **FSM states:** IDLE, ISSUE, DRAIN, DONE.
- **IDLE:**
  - On `start=1`: latch `cfg_in` into `cfg_o`, clear all three metrics and the operand counter, then go to ISSUE.
  - `start` in any other state is ignored.
- **ISSUE:**
  - Each cycle assert `op_valid_o` with `{a_o,b_o}` equal to the operand counter, then increment the counter.
  - Issue order is `b` fastest: `a_o` = counter upper half, `b_o` = counter lower half.
  - After issuing the all-ones pair (counter = `2^(2*BITWIDTH)-1`), go to DRAIN.
- **DRAIN:** wait until the valid shift register (depth `LAT`) is empty, then go to DONE. With `LAT=0`, DRAIN lasts exactly one cycle.
- **DONE:** assert `done` for one cycle, then go to IDLE.
- **Response capture:**
  - Responses are sampled on cycles where the delayed valid bit is 1.
  - `diff = |prod_approx_i - prod_exact_i|`, computed in `2*BITWIDTH+1` bits; the magnitude fits in `2*BITWIDTH` bits.
  - If `diff != 0`, increment `err_cnt`.
  - `err_sum += diff`. The counter width guarantees no overflow; no saturation logic is needed.
  - `err_max = max(err_max, diff)`.
- **abort:**
  - `abort` in ISSUE or DRAIN: go to IDLE on the next edge, flush the valid pipe, and do not pulse `done`.
  - Metrics freeze at their partial values.
  - `abort` and `start` asserted together in IDLE: `start` wins; `abort` has no effect in IDLE.
- **Configuration stability:** `cfg_o` holds from the accepted `start` until the next accepted `start`; it is unchanged by `abort` or `done`. The latched 2-bit code per column is passed through as given; the reserved code 11 is not modified.
- **Metric outputs:** hold their values in IDLE until the next accepted `start`.
- **Reset values:** FSM = IDLE; `cfg_o`, `a_o`, `b_o`, `op_valid_o`, `busy`, `done`, `err_cnt`, `err_sum`, `err_max` all 0; valid pipe cleared.
- **Reset mid-sweep:** identical to power-on; no result is retained.

## Timing
- `start` sampled high at edge t:
  - `busy=1` and the first `op_valid_o` appear at cycle t+1.
  - The final pair is issued at cycle t+N, where N = `2^(2*BITWIDTH)`.
  - The last response is sampled at t+N+LAT.
  - `done=1` and `busy=0` at t+N+LAT+1.
- Total sweep length is N+LAT+1 cycles; for `BITWIDTH=8`, `LAT=2` that is 65539.
- `op_valid_o` is continuous (no bubbles) through ISSUE. It is 0 in IDLE, DRAIN and DONE.
- Metric updates are registered: a response sampled at cycle k is visible on the outputs at k+1.
- All outputs are registered.

## Structure
- **Package `mult_cfg_pkg`:**
  - compressor code constants: `CMP_EXACT=2'b00`, `CMP_POS1=2'b01`, `CMP_POS5=2'b10`, `CMP_RSVD=2'b11`;
  - FSM state enum `sweep_state_t`;
  - width helper localparams (`PW = 2*BITWIDTH`).
- **Sub-module `err_metric_acc`:** abs-diff, count, sum and max registers, with clear and sample-enable inputs. The FSM, operand counter and valid pipe stay in the top level.

## Test plan
- Stub datapath with approx = exact, `LAT=2`, pulse `start` -> `done` at cycle t+65539; `err_cnt=0`, `err_sum=0`, `err_max=0`; `op_valid_o` high for exactly 65536 cycles.
- Stub with approx = exact XOR 1 -> `err_cnt=65536`, `err_sum=65536`, `err_max=1`.
- Stub with approx = exact + 5 only for a=255, b=255 -> `err_cnt=1`, `err_sum=5`, `err_max=5`; checks final-pair capture in DRAIN.
- `abort` at cycle t+100 -> `busy=0` next cycle, no `done`, `err_*` frozen; a second `start` clears metrics and completes normally.
- `start` held high during a sweep, plus `cfg_in` changed mid-sweep -> ignored; `cfg_o` unchanged until the next accepted `start`.
- `rst_n` low at cycle t+500 -> all outputs 0 immediately (asynchronous); FSM in IDLE.

Source files
------------

// File: rtl/approx_mult_sweep_ctrl_pkg.sv
// Shared constants, state type and width helper for the approximate-multiplier
// error-characterisation sweep controller.
package mult_cfg_pkg;

  localparam logic [1:0] CMP_EXACT = 2'b00;
  localparam logic [1:0] CMP_POS1  = 2'b01;
  localparam logic [1:0] CMP_POS5  = 2'b10;
  localparam logic [1:0] CMP_RSVD  = 2'b11;

  localparam int unsigned BITWIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_DRAIN = 2'b10,
    ST_DONE  = 2'b11
  } sweep_state_t;

  function automatic int unsigned prod_w(input int unsigned bw);
    return 2 * bw;
  endfunction

endpackage

// File: rtl/approx_mult_sweep_ctrl_if.sv
// Operand/product bus between the sweep controller and the multiplier datapath.
interface approx_mult_sweep_ctrl_if #(
  parameter int unsigned BITWIDTH = 8,
  parameter int unsigned NCOL     = BITWIDTH
) ();

  logic [2*NCOL-1:0]     cfg_o;
  logic [BITWIDTH-1:0]   a_o;
  logic [BITWIDTH-1:0]   b_o;
  logic                  op_valid_o;
  logic [2*BITWIDTH-1:0] prod_approx_i;
  logic [2*BITWIDTH-1:0] prod_exact_i;

  modport master (
    output cfg_o, a_o, b_o, op_valid_o,
    input  prod_approx_i, prod_exact_i
  );

  modport slave (
    input  cfg_o, a_o, b_o, op_valid_o,
    output prod_approx_i, prod_exact_i
  );

endinterface

// File: rtl/approx_mult_sweep_ctrl_err_metric_acc.sv
// Error metric accumulator: absolute difference between approximate and exact
// products folded into error count, error sum and maximum error.
module err_metric_acc
  import mult_cfg_pkg::*;
#(
  parameter int unsigned BITWIDTH = BITWIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  sample,
  input  logic [2*BITWIDTH-1:0] prod_approx_i,
  input  logic [2*BITWIDTH-1:0] prod_exact_i,
  output logic [2*BITWIDTH:0]   err_cnt,
  output logic [4*BITWIDTH-1:0] err_sum,
  output logic [2*BITWIDTH-1:0] err_max
);

  localparam int unsigned PW = prod_w(BITWIDTH);
  localparam int unsigned SW = 2 * PW;
  localparam logic [PW:0] ONE_W = {{PW{1'b0}}, 1'b1};

  logic [PW:0]    cnt_q, cnt_d;
  logic [SW-1:0]  sum_q, sum_d;
  logic [PW-1:0]  max_q, max_d;
  logic [PW-1:0]  diff_s;

  // Difference taken one bit wider so the sign is visible, then folded to magnitude.
  function automatic logic [PW-1:0] abs_diff(input logic [PW-1:0] x, input logic [PW-1:0] y);
    logic [PW:0] d;
    logic [PW:0] m;
    d = {1'b0, x} - {1'b0, y};
    if (d[PW]) begin
      m = ~d + ONE_W;
    end else begin
      m = d;
    end
    return m[PW-1:0];
  endfunction

  // Next-state of the three metrics; clear has priority over a sample.
  always_comb begin
    diff_s = abs_diff(prod_approx_i, prod_exact_i);
    cnt_d  = cnt_q;
    sum_d  = sum_q;
    max_d  = max_q;
    if (clr) begin
      cnt_d = {(PW+1){1'b0}};
      sum_d = {SW{1'b0}};
      max_d = {PW{1'b0}};
    end else if (sample) begin
      if (diff_s != {PW{1'b0}}) begin
        cnt_d = cnt_q + ONE_W;
      end else begin
        cnt_d = cnt_q;
      end
      sum_d = sum_q + {{(SW-PW){1'b0}}, diff_s};
      if (diff_s > max_q) begin
        max_d = diff_s;
      end else begin
        max_d = max_q;
      end
    end else begin
      cnt_d = cnt_q;
      sum_d = sum_q;
      max_d = max_q;
    end
  end

  // Metric registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {(PW+1){1'b0}};
      sum_q <= {SW{1'b0}};
      max_q <= {PW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
      sum_q <= sum_d;
      max_q <= max_d;
    end
  end

  assign err_cnt = cnt_q;
  assign err_sum = sum_q;
  assign err_max = max_q;

endmodule

// File: rtl/approx_mult_sweep_ctrl.sv
// Exhaustive sweep sequencer: latches a compressor configuration, issues every
// operand pair once (b fastest) and accumulates error metrics on the responses.
module approx_mult_sweep_ctrl
  import mult_cfg_pkg::*;
#(
  parameter int unsigned BITWIDTH = BITWIDTH_DEF,
  parameter int unsigned LAT      = 2,
  parameter int unsigned NCOL     = BITWIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [2*NCOL-1:0]        cfg_in,
  approx_mult_sweep_ctrl_if.master dp,
  output logic                     busy,
  output logic                     done,
  output logic [2*BITWIDTH:0]      err_cnt,
  output logic [4*BITWIDTH-1:0]    err_sum,
  output logic [2*BITWIDTH-1:0]    err_max
);

  localparam int unsigned PW = prod_w(BITWIDTH);

  sweep_state_t      state_q, state_d;
  logic [2*NCOL-1:0] cfg_q, cfg_d;
  logic [PW-1:0]     opnd_q, opnd_d;
  logic              op_valid_q, op_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              clr_s;
  logic              flush_s;
  logic              resp_valid_s;
  logic              pipe_drained_s;

  // The operand register doubles as the sweep counter: {a, b} is the pair index.
  always_comb begin
    state_d    = state_q;
    cfg_d      = cfg_q;
    opnd_d     = opnd_q;
    op_valid_d = 1'b0;
    clr_s      = 1'b0;
    flush_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_ISSUE;
          cfg_d      = cfg_in;
          opnd_d     = {PW{1'b0}};
          op_valid_d = 1'b1;
          clr_s      = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (abort) begin
          state_d = ST_IDLE;
          flush_s = 1'b1;
        end else if (opnd_q == {PW{1'b1}}) begin
          state_d = ST_DRAIN;
        end else begin
          op_valid_d = 1'b1;
          opnd_d     = opnd_q + {{(PW-1){1'b0}}, 1'b1};
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          state_d = ST_IDLE;
          flush_s = 1'b1;
        end else if (pipe_drained_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        flush_s = 1'b1;
      end
    endcase
    busy_d = (state_d == ST_ISSUE) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
  end

  // FSM state and all controller-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cfg_q      <= {(2*NCOL){1'b0}};
      opnd_q     <= {PW{1'b0}};
      op_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      opnd_q     <= opnd_d;
      op_valid_q <= op_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  generate
    if (LAT == 0) begin : g_no_pipe
      assign resp_valid_s   = op_valid_q;
      assign pipe_drained_s = 1'b1;
    end else begin : g_pipe
      logic [LAT-1:0] vpipe_q, vpipe_d;

      // Valid bits travel alongside the datapath; stage LAT-1 marks a live response.
      always_comb begin
        if (flush_s) begin
          vpipe_d = {LAT{1'b0}};
        end else begin
          vpipe_d = LAT'({vpipe_q, op_valid_q});
        end
      end

      // Valid pipe registers.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vpipe_q <= {LAT{1'b0}};
        end else begin
          vpipe_q <= vpipe_d;
        end
      end

      assign resp_valid_s   = vpipe_q[LAT-1];
      assign pipe_drained_s = (LAT'({vpipe_q, 1'b0}) == {LAT{1'b0}});
    end
  endgenerate

  err_metric_acc #(
    .BITWIDTH (BITWIDTH)
  ) u_acc (
    .clk           (clk),
    .rst_n         (rst_n),
    .clr           (clr_s),
    .sample        (resp_valid_s),
    .prod_approx_i (dp.prod_approx_i),
    .prod_exact_i  (dp.prod_exact_i),
    .err_cnt       (err_cnt),
    .err_sum       (err_sum),
    .err_max       (err_max)
  );

  assign dp.cfg_o      = cfg_q;
  assign dp.a_o        = opnd_q[PW-1:BITWIDTH];
  assign dp.b_o        = opnd_q[BITWIDTH-1:0];
  assign dp.op_valid_o = op_valid_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_approx_mult_sweep_ctrl.sv
// Self-checking bench: a stub datapath with selectable error patterns and a
// loop-based reference model of the sweep metrics.
module tb_approx_mult_sweep_ctrl;
  import mult_cfg_pkg::*;

  localparam int BW   = 4;
  localparam int LATC = 2;
  localparam int PWB  = 2 * BW;
  localparam int N    = 1 << PWB;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic [2*BW-1:0]  cfg_in;
  logic             busy;
  logic             done;
  logic [PWB:0]     err_cnt;
  logic [2*PWB-1:0] err_sum;
  logic [PWB-1:0]   err_max;

  approx_mult_sweep_ctrl_if #(.BITWIDTH(BW), .NCOL(BW)) dp_if ();

  approx_mult_sweep_ctrl #(.BITWIDTH(BW), .LAT(LATC), .NCOL(BW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .cfg_in  (cfg_in),
    .dp      (dp_if),
    .busy    (busy),
    .done    (done),
    .err_cnt (err_cnt),
    .err_sum (err_sum),
    .err_max (err_max)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stub datapath: LATC-stage operand delay, then exact and approximate products.
  int             mode;
  logic [PWB-1:0] mask_tab [N];
  logic [BW-1:0]  pa [LATC];
  logic [BW-1:0]  pb [LATC];

  function automatic logic [PWB-1:0] exact_of(input logic [BW-1:0] a, input logic [BW-1:0] b);
    return PWB'(a) * PWB'(b);
  endfunction

  function automatic logic [PWB-1:0] approx_of(input logic [BW-1:0] a, input logic [BW-1:0] b,
                                               input int m, input logic [PWB-1:0] msk);
    logic [PWB-1:0] e;
    e = exact_of(a, b);
    case (m)
      0:       return e;
      1:       return e ^ PWB'(1);
      2:       return ((a == {BW{1'b1}}) && (b == {BW{1'b1}})) ? e + PWB'(5) : e;
      default: return e ^ msk;
    endcase
  endfunction

  always @(posedge clk) begin
    pa[0] <= dp_if.a_o;
    pb[0] <= dp_if.b_o;
    for (int i = 1; i < LATC; i++) begin
      pa[i] <= pa[i-1];
      pb[i] <= pb[i-1];
    end
  end

  always_comb begin
    dp_if.prod_exact_i  = exact_of(pa[LATC-1], pb[LATC-1]);
    dp_if.prod_approx_i = approx_of(pa[LATC-1], pb[LATC-1], mode, mask_tab[{pa[LATC-1], pb[LATC-1]}]);
  end

  int cyc        = 0;
  int opv_total  = 0;
  int done_total = 0;
  int n_cmp      = 0;
  int n_bad      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dp_if.op_valid_o === 1'b1) opv_total <= opv_total + 1;
    if (done === 1'b1) done_total <= done_total + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: metrics after the first k pairs (index = a*2^BW + b) have been scored.
  task automatic model(input int k, output longint c, output longint s, output longint mx);
    c = 0; s = 0; mx = 0;
    for (int p = 0; p < k; p++) begin
      int ai, bi, ex, ap, d;
      ai = p / (1 << BW);
      bi = p % (1 << BW);
      ex = ai * bi;
      ap = int'(approx_of(BW'(ai), BW'(bi), mode, mask_tab[p]));
      d  = (ap > ex) ? ap - ex : ex - ap;
      if (d != 0) c++;
      s += d;
      if (d > mx) mx = d;
    end
  endtask

  task automatic check_metrics(input string tag, input int k);
    longint c, s, mx;
    model(k, c, s, mx);
    chk({tag, ".err_cnt"}, 64'(err_cnt), c);
    chk({tag, ".err_sum"}, 64'(err_sum), s);
    chk({tag, ".err_max"}, 64'(err_max), mx);
  endtask

  function automatic logic [2*BW-1:0] rand_cfg();
    logic [1:0]      codes [4];
    logic [2*BW-1:0] r;
    codes[0] = CMP_EXACT; codes[1] = CMP_POS1; codes[2] = CMP_POS5; codes[3] = CMP_RSVD;
    for (int i = 0; i < BW; i++) r[2*i +: 2] = codes[$urandom_range(0, 3)];
    r[2*BW-1 -: 2] = CMP_RSVD;
    return r;
  endfunction

  task automatic set_mode(input int m);
    mode = m;
    for (int i = 0; i < N; i++)
      mask_tab[i] = (m == 3 && ($urandom_range(0, 1) == 1)) ? PWB'($urandom) : {PWB{1'b0}};
  endtask

  // Drives start at a negedge; returns at the negedge of the first issue cycle.
  task automatic kick(input logic [2*BW-1:0] cfg, input bit with_abort, output int c0);
    start  = 1'b1;
    abort  = with_abort;
    cfg_in = cfg;
    @(negedge clk);
    c0    = cyc;
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic run_sweep(input string tag, input int m, input bit with_abort, input bit hold_start);
    logic [2*BW-1:0] cfg_exp;
    int c0, opv0, done0;
    set_mode(m);
    cfg_exp = rand_cfg();
    opv0    = opv_total;
    done0   = done_total;
    kick(cfg_exp, with_abort, c0);
    chk({tag, ".busy_first"}, 64'(busy), 64'(1));
    chk({tag, ".opv_first"}, 64'(dp_if.op_valid_o), 64'(1));
    chk({tag, ".opnd_first"}, 64'({dp_if.a_o, dp_if.b_o}), 64'(0));
    chk({tag, ".cfg_latch"}, 64'(dp_if.cfg_o), 64'(cfg_exp));
    check_metrics({tag, ".cleared"}, 0);
    while (done !== 1'b1 && (cyc - c0) < N + LATC + 20) begin
      if (hold_start && (cyc - c0) < N / 2) begin
        start  = 1'b1;
        cfg_in = rand_cfg() ^ 8'h5A;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if ((cyc - c0) == N / 2) chk({tag, ".opnd_mid"}, 64'({dp_if.a_o, dp_if.b_o}), 64'(N / 2));
    end
    start = 1'b0;
    chk({tag, ".done_cycle"}, 64'(cyc - c0), 64'(N + LATC));
    chk({tag, ".busy_at_done"}, 64'(busy), 64'(0));
    chk({tag, ".opv_at_done"}, 64'(dp_if.op_valid_o), 64'(0));
    chk({tag, ".cfg_hold"}, 64'(dp_if.cfg_o), 64'(cfg_exp));
    check_metrics({tag, ".final"}, N);
    @(negedge clk);
    chk({tag, ".done_pulse"}, 64'(done), 64'(0));
    chk({tag, ".opv_count"}, 64'(opv_total - opv0), 64'(N));
    chk({tag, ".done_count"}, 64'(done_total - done0), 64'(1));
    check_metrics({tag, ".idle_hold"}, N);
  endtask

  task automatic run_abort(input int a_at);
    logic [2*BW-1:0] cfg_exp;
    int c0, done0;
    set_mode(3);
    cfg_exp = rand_cfg();
    done0   = done_total;
    kick(cfg_exp, 1'b0, c0);
    while ((cyc - c0) < a_at - 1) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort.busy", 64'(busy), 64'(0));
    chk("abort.opv", 64'(dp_if.op_valid_o), 64'(0));
    check_metrics("abort.partial", a_at - LATC);
    repeat (LATC + 4) @(negedge clk);
    check_metrics("abort.frozen", a_at - LATC);
    chk("abort.no_done", 64'(done_total - done0), 64'(0));
    chk("abort.cfg_hold", 64'(dp_if.cfg_o), 64'(cfg_exp));
  endtask

  task automatic run_reset_mid();
    int c0;
    set_mode(1);
    kick(rand_cfg(), 1'b0, c0);
    while ((cyc - c0) < 150) @(negedge clk);
    chk("rst.opnd_before", 64'({dp_if.a_o, dp_if.b_o}), 64'(150));
    check_metrics("rst.before", 150 - LATC);
    #2 rst_n = 1'b0;
    #1;
    chk("rst.busy", 64'(busy), 64'(0));
    chk("rst.done", 64'(done), 64'(0));
    chk("rst.opv", 64'(dp_if.op_valid_o), 64'(0));
    chk("rst.opnd", 64'({dp_if.a_o, dp_if.b_o}), 64'(0));
    chk("rst.cfg", 64'(dp_if.cfg_o), 64'(0));
    check_metrics("rst.metrics", 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst.idle_busy", 64'(busy), 64'(0));
    chk("rst.idle_opv", 64'(dp_if.op_valid_o), 64'(0));
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    cfg_in = {(2*BW){1'b0}};
    set_mode(0);
    repeat (3) @(negedge clk);
    chk("reset.busy", 64'(busy), 64'(0));
    chk("reset.done", 64'(done), 64'(0));
    chk("reset.opv", 64'(dp_if.op_valid_o), 64'(0));
    chk("reset.opnd", 64'({dp_if.a_o, dp_if.b_o}), 64'(0));
    chk("reset.cfg", 64'(dp_if.cfg_o), 64'(0));
    check_metrics("reset", 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle.busy", 64'(busy), 64'(0));

    run_sweep("exact", 0, 1'b0, 1'b0);
    run_sweep("lsb_flip", 1, 1'b1, 1'b0);
    run_sweep("last_pair", 2, 1'b0, 1'b1);
    run_abort($urandom_range(LATC + 1, N - 1));
    run_sweep("random", 3, 1'b0, 1'b0);
    run_reset_mid();
    run_sweep("post_reset", 3, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
